counter_sequencer: RTL and testbench

//   Run-control FSM plus WIDTH-bit counter register, replacing the free-running ripple counter.

---
 rtl/counter_sequencer.sv | 106 ++++++++++
 tb/tb_counter_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Run-control sequencer around a WIDTH-bit up/down counter.
// Start/pause/stop, preset load, terminal flags for timing logic.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  logic             w_term;
  logic [WIDTH-1:0] w_reload;
  logic [WIDTH-1:0] w_step;
  logic             w_in_run;
  logic             w_in_idle;
  logic             w_in_pause;
  logic             w_in_done;

  // Terminal test, reload value and next step from the current direction
  always_comb begin
    w_term     = up ? (r_count >= limit) : (r_count == '0);
    w_reload   = up ? '0 : limit;
    w_step     = up ? (r_count + ONE) : (r_count - ONE);
    w_in_run   = (r_state == S_RUN);
    w_in_idle  = (r_state == S_IDLE);
    w_in_pause = (r_state == S_PAUSE);
    w_in_done  = (r_state == S_DONE);
  end

  // Sequencer FSM; count and all flags are registered here
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else if (load && !w_in_run) begin
        r_count <= load_value;
      end else if (start && w_in_idle) begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
      end else if (start && w_in_done) begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_count <= w_reload;
      end else if (w_in_run) begin
        if (hold) begin
          r_state <= S_PAUSE;
        end else if (!w_term) begin
          r_count <= w_step;
        end else if (mode) begin
          r_count <= w_reload;
          r_wrap  <= 1'b1;
        end else begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else if (w_in_pause && !hold) begin
        r_state <= S_RUN;
      end
    end
  end

  assign count = r_count;
  assign state = r_state;
  assign busy  = r_busy;
  assign done  = r_done;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer.
// Expected outputs are queued per cycle and popped after each edge.
module tb_counter_sequencer;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  typedef struct packed {
    logic [3:0] c;
    logic [1:0] s;
    logic       b;
    logic       d;
    logic       w;
  } exp_t;

  logic       clk;
  logic       clear;
  logic       start;
  logic       stop;
  logic       hold;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] limit;
  logic       up;
  logic       mode;
  logic [3:0] count;
  logic [1:0] state;
  logic       busy;
  logic       done;
  logic       wrap;

  exp_t sb[$];
  int   checks;
  int   errors;

  counter_sequencer #(.WIDTH(4)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .load       (load),
    .load_value (load_value),
    .limit      (limit),
    .up         (up),
    .mode       (mode),
    .count      (count),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t E(input logic [3:0] c, input logic [1:0] s,
                             input logic d = 1'b0, input logic w = 1'b0);
    exp_t e;
    e.c = c;
    e.s = s;
    e.b = (s == RUN) || (s == PAUSE);
    e.d = d;
    e.w = w;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.c = count;
    o.s = state;
    o.b = busy;
    o.d = done;
    o.w = wrap;
    return o;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back(E(4'd0, IDLE));
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset got %h want %h", obs(), e);
    end
  endtask

  task automatic test_oneshot_up();
    exp_t e;
    limit = 4'd3; up = 1'b1; mode = 1'b0;
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd2, RUN));
    sb.push_back(E(4'd3, RUN));
    sb.push_back(E(4'd3, DONE, 1'b1));
    sb.push_back(E(4'd3, DONE));
    sb.push_back(E(4'd3, DONE));
    for (int i = 0; i < 7; i++) begin
      start = (i == 0);
      edge1();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL oneshot_up cyc%0d got %h want %h", i, obs(), e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e;
    limit = 4'd2; up = 1'b1; mode = 1'b1;
    sb.push_back(E(4'd0, IDLE));
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd2, RUN));
    sb.push_back(E(4'd0, RUN, 1'b0, 1'b1));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd2, RUN));
    sb.push_back(E(4'd0, RUN, 1'b0, 1'b1));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd0, IDLE));
    for (int i = 0; i < 10; i++) begin
      stop  = (i == 0) || (i == 9);
      start = (i == 1);
      edge1();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL wrap cyc%0d got %h want %h", i, obs(), e);
      end
    end
    stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_down();
    exp_t e;
    limit = 4'd9; up = 1'b0; mode = 1'b0; load_value = 4'd5;
    sb.push_back(E(4'd5, IDLE));
    sb.push_back(E(4'd5, RUN));
    sb.push_back(E(4'd4, RUN));
    sb.push_back(E(4'd3, RUN));
    sb.push_back(E(4'd2, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd0, DONE, 1'b1));
    sb.push_back(E(4'd0, DONE));
    sb.push_back(E(4'd9, RUN));
    sb.push_back(E(4'd8, RUN));
    sb.push_back(E(4'd0, IDLE));
    for (int i = 0; i < 12; i++) begin
      load  = (i == 0);
      start = (i == 1) || (i == 9);
      stop  = (i == 11);
      edge1();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL down cyc%0d got %h want %h", i, obs(), e);
      end
    end
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    limit = 4'd15; up = 1'b1; mode = 1'b1; load_value = 4'd7;
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd2, RUN));
    sb.push_back(E(4'd2, PAUSE));
    sb.push_back(E(4'd2, PAUSE));
    sb.push_back(E(4'd7, PAUSE));
    sb.push_back(E(4'd7, RUN));
    sb.push_back(E(4'd8, RUN));
    sb.push_back(E(4'd0, IDLE));
    for (int i = 0; i < 9; i++) begin
      start = (i == 0);
      hold  = (i >= 3) && (i <= 5);
      load  = (i == 5);
      stop  = (i == 8);
      edge1();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL hold cyc%0d got %h want %h", i, obs(), e);
      end
    end
    start = 1'b0; hold = 1'b0; load = 1'b0; stop = 1'b0;
  endtask

  task automatic test_stop_start();
    exp_t e;
    limit = 4'd15; up = 1'b1; mode = 1'b0; load_value = 4'd9;
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd2, RUN));
    sb.push_back(E(4'd3, RUN));
    sb.push_back(E(4'd0, IDLE));
    sb.push_back(E(4'd0, IDLE));
    for (int i = 0; i < 6; i++) begin
      start = (i == 0) || (i == 3) || (i == 4);
      load  = (i == 2);
      stop  = (i == 4);
      edge1();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL stop_start cyc%0d got %h want %h", i, obs(), e);
      end
    end
    start = 1'b0; load = 1'b0; stop = 1'b0;
  endtask

  task automatic test_boundary();
    exp_t e;
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd0, RUN, 1'b0, 1'b1));
    sb.push_back(E(4'd0, RUN, 1'b0, 1'b1));
    sb.push_back(E(4'd0, RUN, 1'b0, 1'b1));
    sb.push_back(E(4'd0, IDLE));
    sb.push_back(E(4'd5, IDLE));
    sb.push_back(E(4'd5, RUN));
    sb.push_back(E(4'd5, DONE, 1'b1));
    sb.push_back(E(4'd0, IDLE));
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd2, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd15, RUN, 1'b0, 1'b1));
    sb.push_back(E(4'd0, IDLE));
    for (int i = 0; i < 16; i++) begin
      if (i < 5) begin
        limit = 4'd0; up = 1'b1; mode = 1'b1;
      end else if (i < 9) begin
        limit = 4'd3; up = 1'b1; mode = 1'b0;
      end else begin
        limit = 4'd15; mode = 1'b1; up = (i < 12);
      end
      load_value = 4'd5;
      start = (i == 0) || (i == 6) || (i == 9);
      load  = (i == 5);
      stop  = (i == 4) || (i == 8) || (i == 15);
      edge1();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL boundary cyc%0d got %h want %h", i, obs(), e);
      end
    end
    start = 1'b0; load = 1'b0; stop = 1'b0; up = 1'b1;
  endtask

  task automatic test_clear_async();
    exp_t e;
    limit = 4'd15; up = 1'b1; mode = 1'b1;
    sb.push_back(E(4'd0, RUN));
    sb.push_back(E(4'd1, RUN));
    sb.push_back(E(4'd2, RUN));
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      edge1();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL clr_pre cyc%0d got %h want %h", i, obs(), e);
      end
    end
    start = 1'b0;
    #2;
    clear = 1'b0;
    sb.push_back(E(4'd0, IDLE));
    #1;
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL clr_async got %h want %h", obs(), e);
    end
    #2;
    clear = 1'b1;
    sb.push_back(E(4'd0, IDLE));
    edge1();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL clr_after got %h want %h", obs(), e);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    start = 0; stop = 0; hold = 0; load = 0;
    load_value = '0; limit = '0; up = 1'b1; mode = 1'b0;
    clear = 1'b1;
    #2 clear = 1'b0;
    #1;
    test_reset();
    #1 clear = 1'b1;
    test_oneshot_up();
    test_wrap();
    test_down();
    test_hold();
    test_stop_start();
    test_boundary();
    test_clear_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
